ram_port_arbiter: RTL and testbench

Sequences and shares the single data-RAM port (CE/RD/WR, 8-bit word address, 32-bit data) between two requesters. The data requester is the load/store path (C.SWSP/C.LWSP, SW/LW units). The fetch requester is the instruction fetch path. The block performs byte-to-word address conversion, misalignment checking and read-latency tracking. It returns per-requester grant, completion and read data.

---
 rtl/rv_mem_pkg.sv | 18 +
 rtl/ram_arb_pick.sv | 42 ++++
 rtl/ram_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types for the data-RAM port arbiter.
// State encodings, owner IDs and the default RAM word-address width.
package rv_mem_pkg;

  localparam int RAM_AW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_F = 1'b1
  } owner_e;

endpackage

// File: rtl/ram_arb_pick.sv
// Winner selection between data and fetch requesters.
// Holds the fetch starvation counter.
module ram_arb_pick
  import rv_mem_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic   iCLK,
  input  logic   iRST,
  input  logic   iARB,
  input  logic   iD_REQ,
  input  logic   iF_REQ,
  output logic   oGO,
  output owner_e oWIN
);

  localparam int CW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          win_f;

  always_comb begin
    oGO   = iARB & (iD_REQ | iF_REQ);
    win_f = iF_REQ & (~iD_REQ | (cnt_q == SMAX));
    oWIN  = win_f ? OWN_F : OWN_D;
    cnt_d = cnt_q;
    if (oGO) begin
      if (win_f)
        cnt_d = '0;
      else if (iF_REQ && cnt_q != SMAX)
        cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single data-RAM port between load/store and fetch.
// Converts byte to word addresses, flags misalignment, tracks read latency.
module ram_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 3,
  parameter int AW         = RAM_AW
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iD_REQ,
  input  logic          iD_WR,
  input  logic [31:0]   iD_ADDR,
  input  logic [31:0]   iD_DATA,
  output logic          oD_GNT,
  output logic          oD_VALID,
  output logic [31:0]   oD_Q,
  output logic          oD_ERR,
  input  logic          iF_REQ,
  input  logic [31:0]   iF_ADDR,
  output logic          oF_GNT,
  output logic          oF_VALID,
  output logic [31:0]   oF_Q,
  output logic          oF_ERR,
  output logic          oRAM_CE,
  output logic          oRAM_RD,
  output logic          oRAM_WR,
  output logic [AW-1:0] oRAM_ADDR,
  output logic [31:0]   oRAM_DATA,
  input  logic [31:0]   iRAM_Q
);

  localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY - 1);

  state_e        state_q, state_d;
  owner_e        own_q, own_d;
  logic          wr_q, wr_d;
  logic          mis_q, mis_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [2:0]    lat_q, lat_d;
  logic          dv_q, dv_d, fv_q, fv_d;
  logic          de_q, de_d, fe_q, fe_d;
  logic [31:0]   dq_q, dq_d, fq_q, fq_d;

  logic          go;
  owner_e        win;
  logic          done, done_err;
  logic [31:0]   done_q;
  logic          unused_addr;

  // Upper byte-address bits are intentionally ignored.
  assign unused_addr =
    ^{iD_ADDR[31:AW+2], iF_ADDR[31:AW+2]};

  ram_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iARB   (state_q == ST_IDLE),
    .iD_REQ (iD_REQ),
    .iF_REQ (iF_REQ),
    .oGO    (go),
    .oWIN   (win)
  );

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    wr_d      = wr_q;
    mis_d     = mis_q;
    addr_d    = addr_q;
    data_d    = data_q;
    lat_d     = lat_q;
    dv_d      = 1'b0;
    fv_d      = 1'b0;
    de_d      = de_q;
    fe_d      = fe_q;
    dq_d      = dq_q;
    fq_d      = fq_q;
    done      = 1'b0;
    done_err  = 1'b0;
    done_q    = '0;
    oD_GNT    = 1'b0;
    oF_GNT    = 1'b0;
    oRAM_CE   = 1'b0;
    oRAM_RD   = 1'b0;
    oRAM_WR   = 1'b0;
    oRAM_ADDR = '0;
    oRAM_DATA = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_ACCESS;
          own_d   = win;
          if (win == OWN_F) begin
            wr_d   = 1'b0;
            mis_d  = |iF_ADDR[1:0];
            addr_d = iF_ADDR[AW+1:2];
            data_d = '0;
          end else begin
            wr_d   = iD_WR;
            mis_d  = |iD_ADDR[1:0];
            addr_d = iD_ADDR[AW+1:2];
            data_d = iD_DATA;
          end
        end
      end
      ST_ACCESS: begin
        oD_GNT = (own_q == OWN_D);
        oF_GNT = (own_q == OWN_F);
        if (mis_q) begin
          done     = 1'b1;
          done_err = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          oRAM_CE   = 1'b1;
          oRAM_ADDR = addr_q;
          if (wr_q) begin
            oRAM_WR   = 1'b1;
            oRAM_DATA = data_q;
            done      = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            oRAM_RD = 1'b1;
            lat_d   = LAT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == 3'd0) begin
          done    = 1'b1;
          done_q  = iRAM_Q;
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (done) begin
      if (own_q == OWN_F) begin
        fv_d = 1'b1;
        fq_d = done_q;
        fe_d = done_err;
      end else begin
        dv_d = 1'b1;
        dq_d = done_q;
        de_d = done_err;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      own_q   <= OWN_D;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      lat_q   <= '0;
      dv_q    <= 1'b0;
      fv_q    <= 1'b0;
      de_q    <= 1'b0;
      fe_q    <= 1'b0;
      dq_q    <= '0;
      fq_q    <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      wr_q    <= wr_d;
      mis_q   <= mis_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lat_q   <= lat_d;
      dv_q    <= dv_d;
      fv_q    <= fv_d;
      de_q    <= de_d;
      fe_q    <= fe_d;
      dq_q    <= dq_d;
      fq_q    <= fq_d;
    end
  end

  assign oD_VALID = dv_q;
  assign oD_ERR   = de_q;
  assign oD_Q     = dq_q;
  assign oF_VALID = fv_q;
  assign oF_ERR   = fe_q;
  assign oF_Q     = fq_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a RAM model
// and a transaction-level reference for arbitration and results.
module tb_ram_port_arbiter;

  localparam int RDL = 2;
  localparam int SM  = 3;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          d_req = 1'b0, d_wr = 1'b0;
  logic [31:0]   d_addr = '0, d_data = '0;
  logic          f_req = 1'b0;
  logic [31:0]   f_addr = '0;
  logic          oD_GNT, oD_VALID, oD_ERR;
  logic [31:0]   oD_Q;
  logic          oF_GNT, oF_VALID, oF_ERR;
  logic [31:0]   oF_Q;
  logic          oRAM_CE, oRAM_RD, oRAM_WR;
  logic [AW-1:0] oRAM_ADDR;
  logic [31:0]   oRAM_DATA;
  logic [31:0]   ram_q;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .RD_LATENCY(RDL),
    .STARVE_MAX(SM),
    .AW        (AW)
  ) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iD_REQ   (d_req),
    .iD_WR    (d_wr),
    .iD_ADDR  (d_addr),
    .iD_DATA  (d_data),
    .oD_GNT   (oD_GNT),
    .oD_VALID (oD_VALID),
    .oD_Q     (oD_Q),
    .oD_ERR   (oD_ERR),
    .iF_REQ   (f_req),
    .iF_ADDR  (f_addr),
    .oF_GNT   (oF_GNT),
    .oF_VALID (oF_VALID),
    .oF_Q     (oF_Q),
    .oF_ERR   (oF_ERR),
    .oRAM_CE  (oRAM_CE),
    .oRAM_RD  (oRAM_RD),
    .oRAM_WR  (oRAM_WR),
    .oRAM_ADDR(oRAM_ADDR),
    .oRAM_DATA(oRAM_DATA),
    .iRAM_Q   (ram_q)
  );

  int nchk = 0;
  int nerr = 0;
  int starve = 0;

  function automatic logic [31:0] pat(int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0000;
  endfunction

  // RAM model: data valid on iRAM_Q only in the latency cycle.
  logic [31:0]   mem [256];
  logic [31:0]   refmem [256];
  logic          mem_init = 1'b0;
  logic [7:0]    rd_sh = '0;
  logic [AW-1:0] ra_sh [8];
  logic [31:0]   junk;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else if (oRAM_WR) begin
      mem[oRAM_ADDR] <= oRAM_DATA;
    end
    rd_sh    <= {rd_sh[6:0], oRAM_RD};
    ra_sh[0] <= oRAM_ADDR;
    for (int k = 1; k < 8; k++) ra_sh[k] <= ra_sh[k-1];
  end

  always @(negedge clk) junk <= $urandom;

  assign ram_q = rd_sh[RDL-1] ? mem[ra_sh[RDL-1]] : junk;

  // Requests must be held until granted.
  logic dp = 1'b0, fp = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      dp <= 1'b0;
      fp <= 1'b0;
    end else begin
      assert (!(dp && !d_req && !oD_GNT)) else begin
        nerr++;
        $error("FAIL d_req_dropped: got 0 want 1");
      end
      assert (!(fp && !f_req && !oF_GNT)) else begin
        nerr++;
        $error("FAIL f_req_dropped: got 0 want 1");
      end
      dp <= d_req;
      fp <= f_req;
    end
  end

  function automatic logic [127:0] outs();
    return {oD_GNT, oD_VALID, oD_Q, oD_ERR,
            oF_GNT, oF_VALID, oF_Q, oF_ERR,
            oRAM_CE, oRAM_RD, oRAM_WR,
            oRAM_ADDR, oRAM_DATA};
  endfunction

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] raddr();
    logic [31:0] r;
    r = $urandom;
    r[9:2] = 8'($urandom_range(0, 15));
    if ($urandom % 6 != 0) r[1:0] = 2'b00;
    return r;
  endfunction

  // One arbitration + access, starting at a negedge with the DUT idle.
  task automatic serve(output logic won_f);
    logic        wf, w, mis, bad;
    logic [31:0] a, dat, expq;
    logic [7:0]  wa;
    int          n;
    wf = f_req && (!d_req || starve == SM);
    if (wf) starve = 0;
    else if (f_req && starve < SM) starve++;
    a   = wf ? f_addr : d_addr;
    w   = wf ? 1'b0 : d_wr;
    dat = d_data;
    mis = (a % 4) != 0;
    wa  = 8'((a / 4) % 256);
    @(negedge clk);
    chk("gnt", {oD_GNT, oF_GNT}, {!wf, wf});
    chk("strobes", {oRAM_CE, oRAM_RD, oRAM_WR},
        {!mis, !mis && !w, !mis && w});
    if (!mis) chk("ram_addr", oRAM_ADDR, wa);
    if (!mis && w) chk("ram_data", oRAM_DATA, dat);
    if (wf) f_req = 1'b0;
    else d_req = 1'b0;
    if (w && !mis) refmem[wa] = dat;
    expq = (mis || w) ? 32'h0 : refmem[wa];
    n = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (oRAM_CE | oRAM_RD | oRAM_WR | oD_GNT | oF_GNT |
          (wf ? oD_VALID : oF_VALID))
        bad = 1'b1;
    end while (!(wf ? oF_VALID : oD_VALID) && n < 20);
    chk("valid_lat", n, (mis || w) ? 1 : RDL + 1);
    chk("quiet", bad, 1'b0);
    chk("q", wf ? oF_Q : oD_Q, expq);
    chk("err", wf ? oF_ERR : oD_ERR, mis);
    won_f = wf;
  endtask

  initial begin
    logic       wf;
    logic [4:0] ord;
    int         nv;
    for (int i = 0; i < 256; i++) refmem[i] = pat(i);
    #2 rst = 1'b1;
    #1 chk("reset_outs", outs(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Store alone, then store+load with latency 2
    d_req = 1; d_wr = 1; d_addr = 32'h10; d_data = 32'hDEADBEEF;
    serve(wf);
    d_req = 1; d_wr = 1; d_addr = 32'h20; d_data = 32'h12345678;
    serve(wf);
    d_req = 1; d_wr = 0; d_addr = 32'h20;
    serve(wf);
    chk("load_q_lit", oD_Q, 32'h12345678);

    // Both held: D D D F D
    ord = 5'b01000;
    d_req = 1; d_wr = 0; d_addr = 32'h24;
    f_req = 1; f_addr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      serve(wf);
      chk("order", wf, ord[i]);
      if (i < 4) begin
        d_req = 1;
        f_req = 1;
      end
    end
    serve(wf);

    // Misaligned fetch
    f_req = 1; f_addr = 32'h6;
    serve(wf);
    chk("mis_fetch_err", oF_ERR, 1'b1);

    // Word-address wrap
    d_req = 1; d_wr = 1; d_addr = 32'h400; d_data = 32'hA5A5_0001;
    serve(wf);
    d_req = 1; d_wr = 1; d_addr = 32'h3FC; d_data = 32'hA5A5_00FF;
    serve(wf);
    d_req = 1; d_wr = 0; d_addr = 32'h0;
    serve(wf);

    // Reset during WAIT of a load
    d_req = 1; d_wr = 0; d_addr = 32'h30;
    @(negedge clk);
    chk("rst_gnt", oD_GNT, 1'b1);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("reset_mid_wait", outs(), '0);
    starve = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (oD_VALID | oF_VALID) nv++;
    end
    chk("no_valid_after_rst", nv, 0);
    d_req = 1; d_wr = 0; d_addr = 32'h30;
    serve(wf);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      if (!d_req && ($urandom % 2 == 1)) begin
        d_req = 1; d_wr = 1'($urandom);
        d_addr = raddr(); d_data = $urandom;
      end
      if (!f_req && ($urandom % 2 == 1)) begin
        f_req = 1; f_addr = raddr();
      end
      if (!d_req && !f_req) begin
        d_req = 1; d_wr = 1'($urandom);
        d_addr = raddr(); d_data = $urandom;
      end
      serve(wf);
    end
    while (d_req || f_req) serve(wf);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
